// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operand class bit positions and width helpers used by
// the operand parser, the alignment pipeline and the normaliser.
package fpu_pkg;

  localparam int CLS_ZERO = 0;
  localparam int CLS_INF  = 1;
  localparam int CLS_NAN  = 2;
  localparam int CLS_W    = 3;

  function automatic int op_width(input int exp_w, input int frac_w);
    return 1 + exp_w + frac_w;
  endfunction

  function automatic int sig_width(input int frac_w);
    return frac_w + 1;
  endfunction

endpackage

// File: rtl/align_shifter.sv
// Sticky right shifter: shifts sig_in right and ORs every discarded bit into
// bit 0; shifts of IN_W or more collapse to a lone sticky bit.
module align_shifter #(
  parameter int IN_W    = 27,
  parameter int SHIFT_W = 8
) (
  input  logic [IN_W-1:0]    sig_in,
  input  logic [SHIFT_W-1:0] shift,
  output logic [IN_W-1:0]    sig_out
);

  logic [31:0]     shift_ext;
  logic [IN_W-1:0] lost;
  logic [IN_W-1:0] shifted;
  logic            saturate;

  assign shift_ext = 32'(shift);
  assign shifted   = sig_in >> shift_ext;
  assign saturate  = shift_ext >= 32'(IN_W);

  // A bit is lost when its position lies below the shift amount.
  generate
    for (genvar gi = 0; gi < IN_W; gi++) begin : g_lost
      assign lost[gi] = sig_in[gi] & (shift_ext > 32'(gi));
    end
  endgenerate

  always_comb begin
    sig_out = '0;
    if (saturate) begin
      sig_out = IN_W'(|sig_in);
    end else begin
      sig_out = {shifted[IN_W-1:1], shifted[0] | (|lost)};
    end
  end

endmodule

// File: rtl/operand_align.sv
// Two-stage operand alignment: stage 1 unpacks, classifies and orders the pair,
// stage 2 sticky-shifts the smaller significand; valid/ready with back-pressure.
module operand_align
  import fpu_pkg::*;
#(
  parameter  int EXP_W  = 8,
  parameter  int FRAC_W = 23,
  localparam int W      = op_width(EXP_W, FRAC_W),
  localparam int S      = sig_width(FRAC_W)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [W-1:0]     x_i,
  input  logic [W-1:0]     y_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             swapped_o,
  output logic             big_sign_o,
  output logic             small_sign_o,
  output logic [EXP_W-1:0] exp_o,
  output logic [S-1:0]     big_sig_o,
  output logic [S+2:0]     small_sig_o,
  output logic [CLS_W-1:0] x_class_o,
  output logic [CLS_W-1:0] y_class_o
);

  function automatic logic [CLS_W-1:0] classify(input logic [EXP_W-1:0] e,
                                                input logic [FRAC_W-1:0] f);
    logic [CLS_W-1:0] c;
    c           = '0;
    c[CLS_NAN]  = (&e) & (|f);
    c[CLS_INF]  = (&e) & ~(|f);
    c[CLS_ZERO] = ~(|e) & ~(|f);
    return c;
  endfunction

  logic [EXP_W-1:0]  x_exp, y_exp, x_eff, y_eff;
  logic [FRAC_W-1:0] x_frac, y_frac;
  logic [S-1:0]      x_sig, y_sig;
  logic              swap_next;

  assign x_exp  = x_i[W-2 -: EXP_W];
  assign y_exp  = y_i[W-2 -: EXP_W];
  assign x_frac = x_i[FRAC_W-1:0];
  assign y_frac = y_i[FRAC_W-1:0];
  assign x_sig  = {|x_exp, x_frac};
  assign y_sig  = {|y_exp, y_frac};
  // Subnormals share the minimum normal exponent.
  assign x_eff  = (x_exp == '0) ? EXP_W'(1) : x_exp;
  assign y_eff  = (y_exp == '0) ? EXP_W'(1) : y_exp;
  assign swap_next = y_i[W-2:0] > x_i[W-2:0];

  logic             s1_valid_reg, s2_valid_reg;
  logic             s1_swapped_reg, s1_big_sign_reg, s1_small_sign_reg;
  logic [EXP_W-1:0] s1_exp_reg, s1_shift_reg;
  logic [S-1:0]     s1_big_sig_reg, s1_small_sig_reg;
  logic [CLS_W-1:0] s1_x_class_reg, s1_y_class_reg;
  logic [S+2:0]     aligned_next;
  logic             s1_en, s2_en;

  assign s2_en   = !s2_valid_reg | ready_i;
  assign s1_en   = !s1_valid_reg | s2_en;
  assign ready_o = s1_en;
  assign valid_o = s2_valid_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_reg      <= 1'b0;
      s1_swapped_reg    <= 1'b0;
      s1_big_sign_reg   <= 1'b0;
      s1_small_sign_reg <= 1'b0;
      s1_exp_reg        <= '0;
      s1_shift_reg      <= '0;
      s1_big_sig_reg    <= '0;
      s1_small_sig_reg  <= '0;
      s1_x_class_reg    <= '0;
      s1_y_class_reg    <= '0;
    end else if (s1_en) begin
      s1_valid_reg <= valid_i;
      if (valid_i) begin
        s1_swapped_reg    <= swap_next;
        s1_big_sign_reg   <= swap_next ? y_i[W-1] : x_i[W-1];
        s1_small_sign_reg <= swap_next ? x_i[W-1] : y_i[W-1];
        s1_exp_reg        <= swap_next ? y_exp : x_exp;
        s1_shift_reg      <= swap_next ? (y_eff - x_eff) : (x_eff - y_eff);
        s1_big_sig_reg    <= swap_next ? y_sig : x_sig;
        s1_small_sig_reg  <= swap_next ? x_sig : y_sig;
        s1_x_class_reg    <= classify(x_exp, x_frac);
        s1_y_class_reg    <= classify(y_exp, y_frac);
      end
    end
  end

  align_shifter #(
    .IN_W   (S + 3),
    .SHIFT_W(EXP_W)
  ) u_shifter (
    .sig_in (({s1_small_sig_reg, 3'b000})),
    .shift  (s1_shift_reg),
    .sig_out(aligned_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_reg <= 1'b0;
      swapped_o    <= 1'b0;
      big_sign_o   <= 1'b0;
      small_sign_o <= 1'b0;
      exp_o        <= '0;
      big_sig_o    <= '0;
      small_sig_o  <= '0;
      x_class_o    <= '0;
      y_class_o    <= '0;
    end else if (s2_en) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        swapped_o    <= s1_swapped_reg;
        big_sign_o   <= s1_big_sign_reg;
        small_sign_o <= s1_small_sign_reg;
        exp_o        <= s1_exp_reg;
        big_sig_o    <= s1_big_sig_reg;
        small_sig_o  <= aligned_next;
        x_class_o    <= s1_x_class_reg;
        y_class_o    <= s1_y_class_reg;
      end
    end
  end

endmodule

// File: doc/operand_align.md
# operand_align

Parametrised, pipelined successor to the combinational operand parser. Accepts a pair of IEEE-754-style operands under a valid/ready handshake, unpacks and classifies both, orders them by magnitude, and right-shifts the smaller significand into alignment with guard/round/sticky bits. Sits between the FPU front end and the add/subtract significand datapath.

## Interface
Parameters:
- EXP_W, 8, exponent field width
- FRAC_W, 23, fraction field width. Operand width W = 1+EXP_W+FRAC_W; significand width S = FRAC_W+1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  input pair valid
- ready_o  out  1  block can accept input this cycle
- x_i  in  W  operand x
- y_i  in  W  operand y
- valid_o  out  1  aligned result valid
- ready_i  in  1  downstream accepts result
- swapped_o  out  1  1 = y is the larger-magnitude operand
- big_sign_o, small_sign_o  out  1 each  signs of larger/smaller operand
- exp_o  out  EXP_W  raw exponent field of the larger operand
- big_sig_o  out  S  larger significand (hidden bit included)
- small_sig_o  out  S+3  aligned smaller significand, low 3 bits = G, R, S
- x_class_o, y_class_o  out  3 each  one-hot-or-zero {nan, inf, zero}; all-zero = finite nonzero

## Operation
- Unpack: sign = MSB, exp = next EXP_W bits, frac = low FRAC_W bits.
- Hidden bit = (exp != 0). Effective exponent = exp, or 1 when exp == 0 (subnormal).
- Class: nan = exp all-ones & frac != 0; inf = exp all-ones & frac == 0; zero = exp == 0 & frac == 0.
- Magnitude order: compare {exp, frac}; y strictly greater -> swapped = 1; tie -> swapped = 0.
- Shift d = eff_exp_big - eff_exp_small (unsigned, EXP_W bits).
- small_sig_o = {sig_small, 3'b000} >> d, with bit 0 ORed with every bit shifted out. If d >= S+3, result = {0..., sticky}, sticky = |sig_small.
- Specials are not filtered: alignment is computed from raw fields; class outputs let downstream override.
- Stage 1 registers unpack, class, order, d. Stage 2 registers shifted result and passes the remaining fields through.

## Timing
- Reset: valid_o = 0, all data outputs 0, both stage valid bits 0. Reset mid-operation drops all in-flight pairs; ready_o = 1 in the first cycle after reset deasserts.
- Transfer in on valid_i & ready_o at a rising edge; transfer out on valid_o & ready_i.
- Latency: 2 cycles from accept to valid_o when not stalled; throughput 1 pair/cycle.
- Stage enables: s2_en = !s2_valid | ready_i; s1_en = !s1_valid | s2_en; ready_o = s1_en (combinational from ready_i).
- While valid_o & !ready_i, every output holds stable. Ordering strictly preserved; no drop or duplication.
- Simultaneous out-transfer and in-transfer with full pipeline permitted (ready_o = 1 when ready_i = 1).
- valid_o must not depend combinationally on valid_i.

## Structure
- fpu_pkg: class bit indices (CLS_NAN, CLS_INF, CLS_ZERO), helper function for width derivation; shared with the existing operand parser and later normaliser.
- Sub-module align_shifter: parametrised sticky right shifter (in S+3, shift EXP_W, saturating at S+3); purely combinational, instantiated in stage 2.

## Test plan
- x=3fc00000, y=4500001a -> after 2 cycles: swapped 1, exp_o 8A, big_sig 80001A, small_sig 000C000 (sticky 0), classes 0.
- x=4e800000, y=3f800001 (d=30 >= 27) -> swapped 0, exp_o 9D, big_sig 800000, small_sig 0000001.
- x=00000001, y=00800000 (subnormal, d=0) -> swapped 1, exp_o 01, big_sig 800000, small_sig 0000008.
- x=7fffffff, y=ff800000; then x=y=3fc00000 -> x_class nan, y_class inf; tie gives swapped 0, small_sig 6000000.
- Issue A,B,C back-to-back with ready_i=0 for 5 cycles -> ready_o falls after B is held, outputs stable on A; release -> A,B,C delivered in order, C accepted once ready_o rises.
- Assert rst_i with 2 pairs in flight -> next cycle valid_o 0, outputs 0; no stale pair appears afterwards.
